// File: rtl/conv_accumulator_if.sv
// Product-in / result-out handshake bundle for conv_accumulator.
// slave = accumulator side, master = multiplier/writeback side.
interface conv_accumulator_if #(
    parameter int TAPS   = 9,
    parameter int PROD_W = 14,
    parameter int ACC_W  = 16
);
    localparam int CNT_W = $clog2(TAPS);

    logic signed [PROD_W-1:0] product;
    logic                     p_valid;
    logic                     in_ready;
    logic                     acc_clr;
    logic signed [ACC_W-1:0]  sum_out;
    logic                     sum_valid;
    logic                     sum_ready;
    logic [CNT_W-1:0]         tap_cnt;

    modport slave (
        input  product, p_valid, acc_clr, sum_ready,
        output in_ready, sum_out, sum_valid, tap_cnt
    );

    modport master (
        output product, p_valid, acc_clr, sum_ready,
        input  in_ready, sum_out, sum_valid, tap_cnt
    );
endinterface

// File: rtl/conv_accumulator.sv
// Sums TAPS signed products per output pixel behind a registered valid/ready result stage.
// Optional CONV_ACC_CLAMP_EN clamps the loaded result to the 8-bit pixel range [0,255].
module conv_accumulator #(
    parameter int TAPS   = 9,
    parameter int PROD_W = 14,
    parameter int ACC_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    conv_accumulator_if.slave   bus
);
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
    logic signed [ACC_W-1:0] sum_out_q, sum_out_d;
    logic                    sum_valid_q, sum_valid_d;

    logic                    in_ready;
    logic                    beat;
    logic                    final_beat;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_nx;
    logic signed [ACC_W-1:0] result;

    assign in_ready   = !bus.acc_clr && (!sum_valid_q || bus.sum_ready);
    assign beat       = bus.p_valid && in_ready;
    assign final_beat = beat && (state_q == ACCUM) && (tap_cnt_q == LAST_TAP);
    assign prod_ext   = ACC_W'(bus.product);
    assign sum_nx     = acc_q + prod_ext;

`ifdef CONV_ACC_CLAMP_EN
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'(255);
    always_comb begin
        result = sum_nx;
        if (sum_nx[ACC_W-1])
            result = '0;
        else if (sum_nx > PIX_MAX)
            result = PIX_MAX;
    end
`else
    assign result = sum_nx;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_cnt_d   = tap_cnt_q;
        sum_out_d   = sum_out_q;
        sum_valid_d = sum_valid_q;

        if (sum_valid_q && bus.sum_ready)
            sum_valid_d = 1'b0;

        // acc_clr forces in_ready low, so no beat can race the abort
        if (bus.acc_clr) begin
            state_d   = IDLE;
            acc_d     = '0;
            tap_cnt_d = '0;
        end else if (final_beat) begin
            state_d     = IDLE;
            acc_d       = '0;
            tap_cnt_d   = '0;
            sum_out_d   = result;
            sum_valid_d = 1'b1;
        end else if (beat) begin
            state_d   = ACCUM;
            acc_d     = sum_nx;
            tap_cnt_d = tap_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_cnt_q   <= '0;
            sum_out_q   <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_cnt_q   <= tap_cnt_d;
            sum_out_q   <= sum_out_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.sum_out   = sum_out_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.tap_cnt   = tap_cnt_q;
endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator: window sums are queued at stimulus time
// and compared on every result handshake.
module tb_conv_accumulator;
    localparam int TAPS   = 9;
    localparam int PROD_W = 14;
    localparam int ACC_W  = 16;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   sb[$];

    conv_accumulator_if #(.TAPS(TAPS), .PROD_W(PROD_W), .ACC_W(ACC_W)) bus ();

    conv_accumulator #(.TAPS(TAPS), .PROD_W(PROD_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int v);
`ifdef CONV_ACC_CLAMP_EN
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.sum_valid && bus.sum_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else chk("sum_out", int'($signed(bus.sum_out)), sb.pop_front());
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic beat(input int v);
        int n = 0;
        bus.product = PROD_W'(v);
        bus.p_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("beat_timeout", 0, 1);
        @(posedge clk); #1;
        bus.p_valid = 1'b0;
    endtask

    task automatic window(input int v, input int n);
        for (int i = 0; i < n; i++) beat(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got 1, expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.product   = '0;
        bus.p_valid   = 1'b0;
        bus.acc_clr   = 1'b0;
        bus.sum_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_sum_valid", int'(bus.sum_valid), 0);
        chk("rst_sum_out", int'($signed(bus.sum_out)), 0);
        chk("rst_tap_cnt", int'(bus.tap_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic window, single-cycle valid
        sb.push_back(px(900));
        window(100, 8);
        chk("t1_tap_cnt8", int'(bus.tap_cnt), 8);
        chk("t1_valid_early", int'(bus.sum_valid), 0);
        beat(100);
        chk("t1_valid", int'(bus.sum_valid), 1);
        chk("t1_tap_cnt0", int'(bus.tap_cnt), 0);
        idle(1);
        chk("t1_valid_drop", int'(bus.sum_valid), 0);

        // 2/3: negative and extreme sums
        sb.push_back(px(-8160));
        window(-1020, 8);
        beat(0);
        idle(1);
        sb.push_back(px(16065));
        window(1785, 9);
        sb.push_back(px(-18360));
        window(-2040, 9);
        idle(2);

        // 4: backpressure
        bus.sum_ready = 1'b0;
        sb.push_back(px(90));
        window(10, 9);
        bus.product = PROD_W'(20);
        bus.p_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", int'(bus.sum_valid), 1);
            chk("t4_hold_out", int'($signed(bus.sum_out)), px(90));
            chk("t4_in_ready", int'(bus.in_ready), 0);
            chk("t4_no_accept", int'(bus.tap_cnt), 0);
        end
        @(posedge clk); #1;
        bus.sum_ready = 1'b1;
        sb.push_back(px(180));
        beat(20);
        chk("t4_consumed", int'(bus.sum_valid), 0);
        chk("t4_tap1", int'(bus.tap_cnt), 1);
        window(20, 8);
        chk("t4_valid2", int'(bus.sum_valid), 1);
        idle(1);

        // 5: abort mid-window
        window(50, 4);
        bus.product = PROD_W'(50);
        bus.p_valid = 1'b1;
        bus.acc_clr = 1'b1;
        @(negedge clk);
        chk("t5_in_ready", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        bus.p_valid = 1'b0;
        chk("t5_tap_clr", int'(bus.tap_cnt), 0);
        chk("t5_valid", int'(bus.sum_valid), 0);
        sb.push_back(px(90));
        window(10, 9);
        idle(1);

        // 6: reset mid-window, then gap
        window(7, 5);
        chk("t6_tap5", int'(bus.tap_cnt), 5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("t6_rst_out", int'($signed(bus.sum_out)), 0);
        chk("t6_rst_valid", int'(bus.sum_valid), 0);
        chk("t6_rst_tap", int'(bus.tap_cnt), 0);
        sb.push_back(px(27));
        window(3, 9);
        idle(1);
        sb.push_back(px(27));
        window(3, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_gap_tap", int'(bus.tap_cnt), 4);
        end
        @(posedge clk); #1;
        window(3, 5);
        idle(3);
        chk("sb_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
